unidade_controle: RTL
=====================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have no parameters; the ULA control encoding is fixed: 000 add, 001 sub, 010 and, 011 or, 101 slt (set-less-than).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Op  in  7  opcode of the latched instruction.
REQ-006 Funct3  in  3  instruction bits 14:12.
REQ-007 Funct7b5  in  1  instruction bit 30.
REQ-008 ZeroFlag  in  1  ULA zero flag, sampled combinationally in BRANCH.
REQ-009 ULAControl  out  3  operation select driven to the ULA.
REQ-010 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath enables/selects.
REQ-011 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  mux selects.
REQ-012 IllegalOp  out  1  one-cycle pulse on an unsupported opcode.
REQ-013 Estado  out  4  current FSM state, for debug.

Function
REQ-014 The block SHALL be a Moore multicycle FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-015 The FSM SHALL take these transitions:
- FETCH->DECODE.
- DECODE->MEMADR for lw (0000011) or sw (0100011).
- DECODE->EXECUTER for R-type (0110011).
- DECODE->EXECUTEI for I-type ALU (0010011).
- DECODE->BRANCH for branch (1100011).
- DECODE->JAL for jal (1101111).
- DECODE->FETCH for any other Op, with IllegalOp=1 during that DECODE cycle.
REQ-016 From MEMADR, the FSM SHALL go to MEMREAD when Op=lw and to MEMWRITE otherwise; MEMREAD->MEMWB; MEMWB, MEMWRITE, ALUWB and BRANCH SHALL go to FETCH; EXECUTER, EXECUTEI and JAL SHALL go to ALUWB.
REQ-017 The following outputs SHALL be asserted per state; every output not listed is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10 (constant 4), ResultSrc=10, PC update.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp add.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp add.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp funct.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp funct.
- ALUWB: ResultSrc=00, RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp sub, ResultSrc=00.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PC update.
REQ-018 ImmSrc SHALL be combinational from Op: 00 for lw/I-type, 01 for sw, 10 for branch, 11 for jal, 00 otherwise.
REQ-019 ULAControl SHALL be: ALUOp add -> 000; ALUOp sub -> 001; ALUOp funct -> decoded from Funct3 as follows.
- Funct3=000: 001 if Op[5]&Funct7b5, else 000.
- Funct3=010: 101.
- Funct3=110: 011.
- Funct3=111: 010.
- Any other Funct3: 000.
REQ-020 PCWrite SHALL be PC update OR (BRANCH state AND branch taken); branch taken is Funct3=000 AND ZeroFlag=1.
REQ-021 Instruction latency SHALL be 3 cycles for branch, 4 for R-type, I-type, sw and jal, 5 for lw, and 2 for an illegal opcode.

Reset
REQ-022 While reset=1, the state register SHALL load FETCH and RegWrite, MemWrite, PCWrite, IRWrite and IllegalOp SHALL be forced to 0.
REQ-023 In the first cycle after reset falls, the FSM SHALL be in FETCH with IRWrite=1 and PCWrite=1.
REQ-024 Reset asserted in any state SHALL abort the instruction with no further write enable asserted.

Configuration
REQ-025 With macro UNIDADE_CONTROLE_BNE_EN defined, branch taken SHALL also include Funct3=001 AND ZeroFlag=0 (bne).
REQ-026 Without UNIDADE_CONTROLE_BNE_EN, Funct3=001 (and any Funct3 other than 000) SHALL never assert PCWrite in BRANCH.

Verification
REQ-027 reset=1 for 2 cycles, then release -> Estado=0 and write enables 0 during reset; next cycle IRWrite=1, PCWrite=1, ALUSrcB=10.
REQ-028 Op=0110011, Funct3=000, Funct7b5=1 -> states 0,1,6,8,0; ULAControl=001 in EXECUTER; RegWrite=1 only in ALUWB.
REQ-029 Op=0000011 -> states 0,1,2,3,4; ImmSrc=00; RegWrite=1 with ResultSrc=01 in MEMWB; Op=0100011 -> MemWrite=1 in state 5 only.
REQ-030 Op=1100011, Funct3=000: ZeroFlag=1 -> PCWrite=1 and ULAControl=001 in BRANCH; ZeroFlag=0 -> PCWrite=0.
REQ-031 Op=1100011, Funct3=001, ZeroFlag=0 -> PCWrite=1 with UNIDADE_CONTROLE_BNE_EN defined, PCWrite=0 without it.
REQ-032 Op=1111111 -> IllegalOp=1 for exactly one cycle in DECODE, then FETCH; no RegWrite or MemWrite.

Source files
------------

// File: rtl/unidade_controle_if.sv
// Control-unit bundle: instruction fields and ULA flag in, datapath enables/selects out.
// master = control unit, slave = datapath side.
interface unidade_controle_if;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Funct7b5;
    logic       ZeroFlag;
    logic [2:0] ULAControl;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       IllegalOp;
    logic [3:0] Estado;

    modport master (
        input  Op, Funct3, Funct7b5, ZeroFlag,
        output ULAControl, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, IllegalOp, Estado
    );

    modport slave (
        output Op, Funct3, Funct7b5, ZeroFlag,
        input  ULAControl, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, IllegalOp, Estado
    );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle RISC-V Moore control FSM with ULA decoder.
// Define UNIDADE_CONTROLE_BNE_EN to also take branches on bne (Funct3=001, ZeroFlag=0).
module unidade_controle (
    input  logic clk,
    input  logic reset,
    unidade_controle_if.master bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    logic [3:0] estado, proximo;
    logic [1:0] aluop;
    logic       ilegal, pcupdate, branch, taken;
    logic       irwrite, regwrite, memwrite;

    always_ff @(posedge clk) begin
        if (reset) estado <= FETCH;
        else       estado <= proximo;
    end

    always_comb begin
        proximo = FETCH;
        ilegal  = 1'b0;
        case (estado)
            FETCH:   proximo = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: proximo = MEMADR;
                    OP_R:         proximo = EXECUTER;
                    OP_I:         proximo = EXECUTEI;
                    OP_BR:        proximo = BRANCH;
                    OP_JAL:       proximo = JAL;
                    default: begin
                        proximo = FETCH;
                        ilegal  = 1'b1;
                    end
                endcase
            end
            MEMADR:  proximo = (bus.Op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: proximo = MEMWB;
            EXECUTER, EXECUTEI, JAL: proximo = ALUWB;
            default: proximo = FETCH;
        endcase
    end

    always_comb begin
        irwrite       = 1'b0;
        regwrite      = 1'b0;
        memwrite      = 1'b0;
        pcupdate      = 1'b0;
        branch        = 1'b0;
        aluop         = ALU_ADD;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        case (estado)
            FETCH: begin
                irwrite       = 1'b1;
                pcupdate      = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            MEMREAD:  bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                regwrite      = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                memwrite   = 1'b1;
            end
            EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                aluop       = ALU_FUNCT;
            end
            EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                aluop       = ALU_FUNCT;
            end
            ALUWB:    regwrite = 1'b1;
            BRANCH: begin
                bus.ALUSrcA = 2'b10;
                aluop       = ALU_SUB;
                branch      = 1'b1;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pcupdate    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (aluop)
            ALU_ADD: bus.ULAControl = 3'b000;
            ALU_SUB: bus.ULAControl = 3'b001;
            default: begin
                case (bus.Funct3)
                    3'b000:  bus.ULAControl = (bus.Op[5] & bus.Funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.ULAControl = 3'b101;
                    3'b110:  bus.ULAControl = 3'b011;
                    3'b111:  bus.ULAControl = 3'b010;
                    default: bus.ULAControl = 3'b000;
                endcase
            end
        endcase
    end

    always_comb begin
        case (bus.Op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BR:   bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

`ifdef UNIDADE_CONTROLE_BNE_EN
    assign taken = ((bus.Funct3 == 3'b000) &  bus.ZeroFlag)
                 | ((bus.Funct3 == 3'b001) & ~bus.ZeroFlag);
`else
    assign taken = (bus.Funct3 == 3'b000) & bus.ZeroFlag;
`endif

    // Write enables are gated by reset so an aborted instruction commits nothing.
    assign bus.PCWrite   = ~reset & (pcupdate | (branch & taken));
    assign bus.IRWrite   = ~reset & irwrite;
    assign bus.RegWrite  = ~reset & regwrite;
    assign bus.MemWrite  = ~reset & memwrite;
    assign bus.IllegalOp = ~reset & ilegal;
    assign bus.Estado    = estado;
endmodule
